// File: rtl/audio_frame_tx.sv
// Serial audio frame transmitter: bus-written PCM FIFO feeding a left-justified
// 64-slot frame (AbitClk / Async / Asdo) for the downstream DAC stage.
module audio_frame_tx #(
  parameter int CLK_DIV = 8,
  parameter int FIFO_AW = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  Addr,
  input  logic [15:0] DataWr,
  output logic [15:0] DataRd,
  input  logic        En,
  input  logic        Rd,
  input  logic        Wr,
  output logic        AbitClk,
  output logic        Async,
  output logic        Asdo,
  output logic        Irq
);

  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int LW     = FIFO_AW + 1;
  localparam int DIV_W  = $clog2(CLK_DIV);

  logic                     enable, mono, overflow, underrun;
  logic signed [DATA_W-1:0] fifoMem [DEPTH];
  logic [FIFO_AW-1:0]       wrPtr, rdPtr, rdPtrNext;
  logic [LW-1:0]            level;
  logic [DIV_W-1:0]         divCnt;
  logic                     phase;
  logic [5:0]               slot;
  logic signed [DATA_W-1:0] leftSr, rightSr;

  logic       wrEn, ctrlWr, statWr, fifoWr, pushOk;
  logic       startEn, stopEn, slotEnd, divEnd, load, loadMono, haveWords;
  logic [1:0] need, popCnt;
  logic       unusedRd;

  assign unusedRd = Rd;

  // Bus decode
  assign wrEn   = En & Wr;
  assign ctrlWr = wrEn && (Addr == 4'd0);
  assign statWr = wrEn && (Addr == 4'd1);
  assign fifoWr = wrEn && (Addr == 4'd2);
  assign pushOk = fifoWr && (level < LW'(DEPTH));

  assign startEn = ctrlWr & DataWr[0] & ~enable;
  assign stopEn  = ctrlWr & ~DataWr[0];
  assign divEnd  = (divCnt == DIV_W'(CLK_DIV - 1));
  assign slotEnd = enable & phase & divEnd;

  // A CTRL write in the load cycle already selects the mode for that load
  assign loadMono  = ctrlWr ? DataWr[1] : mono;
  assign load      = startEn | (slotEnd & (slot == 6'd63) & ~stopEn);
  assign need      = loadMono ? 2'd1 : 2'd2;
  assign haveWords = (level >= LW'(need));
  assign popCnt    = (load & haveWords) ? need : 2'd0;
  assign rdPtrNext = rdPtr + FIFO_AW'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      enable   <= 1'b0;
      mono     <= 1'b0;
      overflow <= 1'b0;
      underrun <= 1'b0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
    end else begin
      if (ctrlWr) begin
        enable <= DataWr[0];
        mono   <= DataWr[1];
      end
      overflow <= (fifoWr & ~pushOk) | (overflow & ~(statWr & DataWr[15]));
      underrun <= (load & ~haveWords) | (underrun & ~(statWr & DataWr[14]));
      wrPtr    <= wrPtr + FIFO_AW'(pushOk);
      rdPtr    <= rdPtr + FIFO_AW'(popCnt);
      level    <= level + LW'(pushOk) - LW'(popCnt);
    end
  end

  always_ff @(posedge Clk) begin
    if (pushOk)
      fifoMem[wrPtr] <= DataWr;
  end

  // Slot timing: low half then high half of AbitClk, slot advances on the fall
  always_ff @(posedge Clk) begin
    if (Reset) begin
      divCnt <= '0;
      phase  <= 1'b0;
      slot   <= '0;
    end else if (startEn || !enable || stopEn) begin
      divCnt <= '0;
      phase  <= 1'b0;
      slot   <= '0;
    end else if (divEnd) begin
      divCnt <= '0;
      phase  <= ~phase;
      if (phase)
        slot <= slot + 6'd1;
    end else begin
      divCnt <= divCnt + DIV_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (load) begin
      if (haveWords) begin
        leftSr  <= fifoMem[rdPtr];
        rightSr <= loadMono ? fifoMem[rdPtr] : fifoMem[rdPtrNext];
      end else begin
        leftSr  <= '0;
        rightSr <= '0;
      end
    end else if (slotEnd && !slot[4]) begin
      if (slot[5])
        rightSr <= rightSr <<< 1;
      else
        leftSr <= leftSr <<< 1;
    end
  end

  assign AbitClk = phase;
  assign Async   = slot[5];
  assign Asdo    = enable & ~slot[4] & (slot[5] ? rightSr[DATA_W-1] : leftSr[DATA_W-1]);
  assign Irq     = enable & (level <= LW'(DEPTH / 2));

  always_comb begin
    DataRd = '0;
    case (Addr)
      4'd0:    DataRd = {14'd0, mono, enable};
      4'd1:    DataRd = {overflow, underrun, 6'd0, 8'(level)};
      default: DataRd = '0;
    endcase
  end

endmodule

// File: tb/tb_audio_frame_tx.sv
// Directed bench for audio_frame_tx: scoreboard queue of pushed samples,
// popped at each frame load and compared with the captured serial frame.
module tb_audio_frame_tx;

  localparam int CD    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Addr = '0;
  logic [15:0] DataWr = '0;
  logic [15:0] DataRd;
  logic        En = 1'b0, Rd = 1'b0, Wr = 1'b0;
  logic        AbitClk, Async, Asdo, Irq;

  int passed = 0;
  int total  = 0;
  logic [15:0] sbq [$];

  audio_frame_tx #(.CLK_DIV(CD), .FIFO_AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Addr(Addr), .DataWr(DataWr), .DataRd(DataRd),
    .En(En), .Rd(Rd), .Wr(Wr), .AbitClk(AbitClk), .Async(Async), .Asdo(Asdo),
    .Irq(Irq)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [15:0] d);
    @(posedge Clk); #1;
    En = 1'b1; Wr = 1'b1; Addr = a; DataWr = d;
    @(posedge Clk); #1;
    En = 1'b0; Wr = 1'b0;
  endtask

  task automatic busRead(input logic [3:0] a, output logic [15:0] d);
    Addr = a; Rd = 1'b1; En = 1'b1;
    #1;
    d = DataRd;
    Rd = 1'b0; En = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    if (sbq.size() < DEPTH) sbq.push_back(d);
    busWrite(4'd2, d);
  endtask

  task automatic modelLoad(input bit m, output logic [15:0] l, output logic [15:0] r);
    l = '0; r = '0;
    if (m && sbq.size() >= 1) begin
      l = sbq.pop_front(); r = l;
    end else if (!m && sbq.size() >= 2) begin
      l = sbq.pop_front(); r = sbq.pop_front();
    end
  endtask

  // Called in the first cycle of slot 0; samples every cycle of nSlots slots.
  task automatic captureFrame(input int nSlots, output logic [63:0] sdo,
                              output logic [63:0] fs, output bit clkOk);
    logic a0, d0;
    sdo = '0; fs = '0; clkOk = 1'b1; a0 = 1'b0; d0 = 1'b0;
    for (int s = 0; s < nSlots; s++) begin
      for (int c = 0; c < 2 * CD; c++) begin
        @(negedge Clk);
        if (c == 0) begin
          a0 = Async; d0 = Asdo;
        end else if (Async !== a0 || Asdo !== d0) begin
          clkOk = 1'b0;
        end
        if (AbitClk !== (c >= CD)) clkOk = 1'b0;
      end
      sdo[63-s] = d0;
      fs[63-s]  = a0;
    end
  endtask

  initial begin
    logic [15:0] rd, l, r;
    logic [63:0] sdo, fs;
    bit          clkOk;
    logic [63:0] fsExp;
    fsExp = {32'h0, 32'hFFFF_FFFF};

    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;

    // Reset state
    busRead(4'd0, rd); check("rst_ctrl", rd, 16'h0000);
    busRead(4'd1, rd); check("rst_status", rd, 16'h0000);
    check("rst_abitclk", AbitClk, 1'b0);
    check("rst_async", Async, 1'b0);
    check("rst_asdo", Asdo, 1'b0);
    check("rst_irq", Irq, 1'b0);

    // Basic stereo frame
    push(16'h8001); push(16'h7FFE);
    busRead(4'd1, rd); check("lvl_two", rd, 16'h0002);
    busWrite(4'd0, 16'h0001);
    modelLoad(1'b0, l, r);
    busRead(4'd1, rd); check("lvl_zero_after_load", rd, 16'h0000);
    check("irq_low_level", Irq, 1'b1);
    captureFrame(64, sdo, fs, clkOk);
    check("frame1_sdo", sdo, {l, 16'h0, r, 16'h0});
    check("frame1_sdo_lit", sdo, {16'h8001, 16'h0, 16'h7FFE, 16'h0});
    check("frame1_async", fs, fsExp);
    check("frame1_clk", clkOk, 1'b1);

    // Empty FIFO: zeros and Underrun
    modelLoad(1'b0, l, r);
    captureFrame(64, sdo, fs, clkOk);
    check("underrun_sdo", sdo, {l, 16'h0, r, 16'h0});
    busRead(4'd1, rd); check("underrun_status", rd, 16'h4000);
    busWrite(4'd0, 16'h0000);
    busWrite(4'd1, 16'h4000);
    busRead(4'd1, rd); check("underrun_clear", rd, 16'h0000);

    // Overflow: 17 pushes, one dropped
    for (int i = 0; i < DEPTH + 1; i++) push(16'($urandom_range(0, 65535)));
    busRead(4'd1, rd); check("ovf_status", rd, 16'h8010);
    check("ovf_irq_disabled", Irq, 1'b0);
    busWrite(4'd0, 16'h0001);
    for (int f = 0; f < 3; f++) begin
      modelLoad(1'b0, l, r);
      captureFrame(64, sdo, fs, clkOk);
      check("ovf_frame_sdo", sdo, {l, 16'h0, r, 16'h0});
      check("ovf_frame_clk", clkOk, 1'b1);
      if (f == 0) check("irq_level14", Irq, 1'b0);
    end

    // Abort mid right half
    modelLoad(1'b0, l, r);
    captureFrame(40, sdo, fs, clkOk);
    check("partial_sdo", sdo[63:24], {l, 16'h0, r[15:8]});
    check("partial_async", Async, 1'b1);
    check("irq_level8", Irq, 1'b1);
    busWrite(4'd0, 16'h0000);
    check("dis_abitclk", AbitClk, 1'b0);
    check("dis_async", Async, 1'b0);
    check("dis_asdo", Asdo, 1'b0);
    check("dis_irq", Irq, 1'b0);
    busRead(4'd1, rd); check("dis_status", rd, 16'h8008);

    // Re-enable: restart with next pair, drain, then the dropped word is absent
    busWrite(4'd0, 16'h0001);
    for (int f = 0; f < 5; f++) begin
      modelLoad(1'b0, l, r);
      captureFrame(64, sdo, fs, clkOk);
      check("drain_sdo", sdo, {l, 16'h0, r, 16'h0});
      check("drain_async", fs, fsExp);
    end
    check("drain_last_zero", sdo, 64'h0);
    check("sb_empty", 64'(sbq.size()), 64'd0);
    busRead(4'd1, rd); check("drain_status", rd, 16'hC000);

    // Mono
    busWrite(4'd0, 16'h0002);
    busWrite(4'd1, 16'hC000);
    busRead(4'd1, rd); check("flags_clear", rd, 16'h0000);
    busRead(4'd0, rd); check("ctrl_mono", rd, 16'h0002);
    push(16'h1234);
    busRead(4'd1, rd); check("mono_lvl1", rd, 16'h0001);
    busWrite(4'd0, 16'h0003);
    modelLoad(1'b1, l, r);
    busRead(4'd1, rd); check("mono_lvl0", rd, 16'h0000);
    captureFrame(64, sdo, fs, clkOk);
    check("mono_sdo", sdo, {l, 16'h0, r, 16'h0});
    check("mono_sdo_lit", sdo, {16'h1234, 16'h0, 16'h1234, 16'h0});
    check("mono_clk", clkOk, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
